// File: rtl/modea_calc_n.sv
// Multi-digit ASCII calculator: parses "A op B <Enter>", evaluates the result,
// converts it to decimal with double-dabble and streams it with CR LF over a ready/send handshake.
module modea_calc_n #(
  parameter int DIGITS = 4,
  parameter int OP_W   = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ascii_in,
  input  logic       flag,
  input  logic       ready,
  output logic       send,
  output logic [7:0] ascii_out,
  output logic [2:0] state,
  output logic       error
);

  localparam int RES_W      = 2 * OP_W + 1;
  localparam int OUT_DIGITS = 2 * DIGITS;
  localparam int MAG_W      = RES_W - 1;
  localparam int BCD_W      = 4 * OUT_DIGITS;
  localparam int CNT_W      = $clog2(DIGITS + 1);
  localparam int CONV_W     = $clog2(RES_W);
  localparam int DIG_W      = (OUT_DIGITS > 1) ? $clog2(OUT_DIGITS) : 1;

  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DIGITS);
  localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(RES_W - 2);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_OPA  = 3'd1,
    S_OPB  = 3'd2,
    S_CALC = 3'd3,
    S_CONV = 3'd4,
    S_SEND = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_t;

  typedef enum logic [2:0] {
    PH_SIGN = 3'd0,
    PH_DIG  = 3'd1,
    PH_E    = 3'd2,
    PH_CR   = 3'd3,
    PH_LF   = 3'd4
  } phase_t;

  state_t              state_q, state_d;
  op_t                 op_q, op_d;
  phase_t              phase_q, phase_d;
  logic [OP_W-1:0]     a_q, a_d;
  logic [OP_W-1:0]     b_q, b_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic [MAG_W-1:0]    mag_q, mag_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [CONV_W-1:0]   conv_cnt_q, conv_cnt_d;
  logic [DIG_W-1:0]    dig_q, dig_d;
  logic                send_q, send_d;
  logic [7:0]          ascii_out_q, ascii_out_d;
  logic                error_q, error_d;

  logic                is_digit, is_op, is_enter;
  logic [OP_W-1:0]     key_val;
  op_t                 key_op;
  logic signed [RES_W-1:0] a_ext, b_ext, res;
  logic                res_neg;
  logic [MAG_W-1:0]    res_mag;
  logic [BCD_W-1:0]    bcd_adj, bcd_shift;
  logic [DIG_W-1:0]    msd;
  logic [3:0]          cur_nib;
  logic [7:0]          tx_char;
  logic                fire;

  always_comb begin
    is_digit = (ascii_in >= 8'h30) && (ascii_in <= 8'h39);
    is_op    = (ascii_in == 8'h2B) || (ascii_in == 8'h2D) || (ascii_in == 8'h2A);
    is_enter = (ascii_in == 8'h0A) || (ascii_in == 8'h0D);
    key_val  = OP_W'(ascii_in[3:0]);
    if (ascii_in == 8'h2B)      key_op = OP_ADD;
    else if (ascii_in == 8'h2D) key_op = OP_SUB;
    else                        key_op = OP_MUL;
  end

  // Operands are unsigned; the product of two OP_W values never reaches the sign bit.
  always_comb begin
    a_ext = $signed({{(RES_W - OP_W){1'b0}}, a_q});
    b_ext = $signed({{(RES_W - OP_W){1'b0}}, b_q});
    case (op_q)
      OP_SUB:  res = a_ext - b_ext;
      OP_MUL:  res = a_ext * b_ext;
      default: res = a_ext + b_ext;
    endcase
    res_neg = res[RES_W-1];
    res_mag = res_neg ? (~res[MAG_W-1:0]) + MAG_W'(1) : res[MAG_W-1:0];
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < OUT_DIGITS; i++) begin
      if (bcd_adj[4*i +: 4] > 4'd4) bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
    end
    bcd_shift = {bcd_adj[BCD_W-2:0], mag_q[MAG_W-1]};
    // Highest non-zero digit of the finished BCD value; zero collapses to digit 0.
    msd = '0;
    for (int unsigned i = 0; i < OUT_DIGITS; i++) begin
      if (bcd_shift[4*i +: 4] != 4'd0) msd = DIG_W'(i);
    end
  end

  always_comb begin
    cur_nib = bcd_q[4*dig_q +: 4];
    case (phase_q)
      PH_SIGN: tx_char = 8'h2D;
      PH_DIG:  tx_char = {4'h3, cur_nib};
      PH_E:    tx_char = 8'h45;
      PH_CR:   tx_char = 8'h0D;
      PH_LF:   tx_char = 8'h0A;
      default: tx_char = 8'h00;
    endcase
    fire = ready && !send_q;
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    phase_d     = phase_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    mag_d       = mag_q;
    bcd_d       = bcd_q;
    conv_cnt_d  = conv_cnt_q;
    dig_d       = dig_q;
    send_d      = 1'b0;
    ascii_out_d = ascii_out_q;

    case (state_q)
      S_IDLE: begin
        if (flag && is_digit) begin
          a_d     = key_val;
          b_d     = '0;
          cnt_d   = CNT_W'(1);
          state_d = S_OPA;
        end
      end
      S_OPA: begin
        if (flag) begin
          if (is_digit) begin
            if (cnt_q == CNT_MAX) begin
              state_d = S_ERR;
            end else begin
              a_d   = a_q * OP_W'(10) + key_val;
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (is_op) begin
            op_d    = key_op;
            b_d     = '0;
            cnt_d   = '0;
            state_d = S_OPB;
          end else if (is_enter) begin
            state_d = S_ERR;
          end
        end
      end
      S_OPB: begin
        if (flag) begin
          if (is_digit) begin
            if (cnt_q == CNT_MAX) begin
              state_d = S_ERR;
            end else begin
              b_d   = b_q * OP_W'(10) + key_val;
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (is_enter) begin
            state_d = (cnt_q == '0) ? S_ERR : S_CALC;
          end else if (is_op) begin
            state_d = S_ERR;
          end
        end
      end
      S_CALC: begin
        neg_d      = res_neg;
        mag_d      = res_mag;
        bcd_d      = '0;
        conv_cnt_d = '0;
        state_d    = S_CONV;
      end
      S_CONV: begin
        bcd_d      = bcd_shift;
        mag_d      = {mag_q[MAG_W-2:0], 1'b0};
        conv_cnt_d = conv_cnt_q + CONV_W'(1);
        if (conv_cnt_q == CONV_LAST) begin
          dig_d   = msd;
          phase_d = neg_q ? PH_SIGN : PH_DIG;
          state_d = S_SEND;
        end
      end
      S_SEND, S_ERR: begin
        if (fire) begin
          send_d      = 1'b1;
          ascii_out_d = tx_char;
          case (phase_q)
            PH_SIGN: phase_d = PH_DIG;
            PH_DIG: begin
              if (dig_q == '0) phase_d = PH_CR;
              else             dig_d   = dig_q - DIG_W'(1);
            end
            PH_E:  phase_d = PH_CR;
            PH_CR: phase_d = PH_LF;
            default: begin
              a_d     = '0;
              b_d     = '0;
              cnt_d   = '0;
              state_d = S_IDLE;
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Every path into ERR starts the error string at its first character.
    if (state_d == S_ERR && state_q != S_ERR) phase_d = PH_E;
    error_d = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_ADD;
      phase_q     <= PH_SIGN;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      mag_q       <= '0;
      bcd_q       <= '0;
      conv_cnt_q  <= '0;
      dig_q       <= '0;
      send_q      <= 1'b0;
      ascii_out_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      phase_q     <= phase_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      mag_q       <= mag_d;
      bcd_q       <= bcd_d;
      conv_cnt_q  <= conv_cnt_d;
      dig_q       <= dig_d;
      send_q      <= send_d;
      ascii_out_q <= ascii_out_d;
      error_q     <= error_d;
    end
  end

  assign send      = send_q;
  assign ascii_out = ascii_out_q;
  assign state     = state_q;
  assign error     = error_q;

endmodule

// File: tb/tb_modea_calc_n.sv
// Bench for modea_calc_n: fixed vectors, handshake/reset corner sequences and
// random expressions checked against an integer-arithmetic reference.
module tb_modea_calc_n;
  localparam int DIGITS = 4;
  localparam int OP_W   = 14;

  typedef logic [7:0] u8;
  typedef struct {
    string name;
    string keys;
    u8     enter;
    string exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flag = 1'b0;
  logic       ready = 1'b1;
  logic [7:0] ascii_in = 8'h00;
  logic       send, error;
  logic [7:0] ascii_out;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;
  u8  rx_q[$];
  int gap_viol  = 0;
  int hold_viol = 0;
  logic send_prev = 1'b0;
  u8    last_out  = 8'h00;
  string crlf;
  vec_t  vq[$];

  always #5 clk = ~clk;

  modea_calc_n #(.DIGITS(DIGITS), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .ascii_in(ascii_in), .flag(flag), .ready(ready),
    .send(send), .ascii_out(ascii_out), .state(state), .error(error)
  );

  always @(negedge clk) begin
    if (rst) begin
      if (send) begin
        rx_q.push_back(ascii_out);
        if (send_prev) gap_viol++;
      end else if (ascii_out != last_out) begin
        hold_viol++;
      end
      send_prev = send;
    end else begin
      send_prev = 1'b0;
    end
    last_out = ascii_out;
  end

  function automatic string hexs(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) r = $sformatf("%s%02h ", r, s[i]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic chk_str(input string name, input string got, input string exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=[%s] expected=[%s]", name, hexs(got), hexs(exp));
    end
  endtask

  task automatic key(input u8 c);
    @(posedge clk); #1;
    ascii_in = c;
    flag = 1'b1;
    @(posedge clk); #1;
    flag = 1'b0;
    ascii_in = 8'h00;
    repeat (2) @(posedge clk);
  endtask

  task automatic type_str(input string s);
    for (int i = 0; i < s.len(); i++) key(s[i]);
  endtask

  // Waits (bounded) until n characters are in the queue, then drains any stragglers too.
  task automatic collect(input int n, input bit rnd, output string got);
    int cyc = 0;
    got = "";
    while (rx_q.size() < n && cyc < 3000) begin
      @(posedge clk); #2;
      if (rnd) ready = ($urandom_range(0, 3) != 0);
      cyc++;
    end
    ready = 1'b1;
    repeat (10) @(posedge clk);
    while (rx_q.size() > 0) got = $sformatf("%s%c", got, rx_q.pop_front());
  endtask

  task automatic wait_rx(input int n);
    int cyc = 0;
    while (rx_q.size() < n && cyc < 500) begin
      @(posedge clk); #2;
      cyc++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    string got;
    rx_q.delete();
    type_str(v.keys);
    if (v.enter != 8'h00) key(v.enter);
    collect(v.exp.len(), 1'b0, got);
    chk_str(v.name, got, v.exp);
    chk({v.name, "_idle"}, state, 0);
  endtask

  task automatic add_vec(input string n, input string k, input u8 e, input string x);
    vec_t v;
    v.name = n; v.keys = k; v.enter = e; v.exp = x;
    vq.push_back(v);
  endtask

  // Reference: interpret keystrokes with integer arithmetic, stop at the first terminal event.
  function automatic void model(input u8 keys[$], output string exp, output int used);
    int     ph = 0;
    int     cnt = 0;
    longint a = 0, b = 0, r;
    u8      op = 8'h00;
    bit     done = 0;
    exp  = "";
    used = keys.size();
    for (int i = 0; i < keys.size(); i++) begin
      u8 c = keys[i];
      if (!done) begin
        if (c >= 8'h30 && c <= 8'h39) begin
          if (ph == 0) begin
            a = c - 8'h30; cnt = 1; ph = 1;
          end else if (cnt == DIGITS) begin
            exp = {"E", crlf}; used = i + 1; done = 1;
          end else if (ph == 1) begin
            a = a * 10 + (c - 8'h30); cnt++;
          end else begin
            b = b * 10 + (c - 8'h30); cnt++;
          end
        end else if (c == 8'h2B || c == 8'h2D || c == 8'h2A) begin
          if (ph == 1) begin
            op = c; b = 0; cnt = 0; ph = 2;
          end else if (ph == 2) begin
            exp = {"E", crlf}; used = i + 1; done = 1;
          end
        end else if (c == 8'h0A || c == 8'h0D) begin
          if (ph == 1 || (ph == 2 && cnt == 0)) begin
            exp = {"E", crlf}; used = i + 1; done = 1;
          end else if (ph == 2) begin
            if (op == 8'h2B)      r = a + b;
            else if (op == 8'h2D) r = a - b;
            else                  r = a * b;
            exp = $sformatf("%0d%s", r, crlf);
            used = i + 1; done = 1;
          end
        end
      end
    end
  endfunction

  initial begin
    string got;
    crlf = $sformatf("%c%c", 8'h0D, 8'h0A);

    repeat (3) @(posedge clk); #1;
    chk("reset_outputs", {send, ascii_out, state, error}, 0);
    #3 rst = 1'b1;
    repeat (2) @(posedge clk);

    add_vec("add_6p3",     "6+3",        8'h0D, {"9", crlf});
    add_vec("sub_neg",     "12-45",      8'h0A, {"-33", crlf});
    add_vec("mul_max",     "9999*9999",  8'h0D, {"99980001", crlf});
    add_vec("zero",        "0+0",        8'h0D, {"0", crlf});
    add_vec("a_overflow",  "12345",      8'h00, {"E", crlf});
    add_vec("op_in_b",     "12+3+",      8'h00, {"E", crlf});
    add_vec("empty_b",     "7-",         8'h0D, {"E", crlf});
    add_vec("enter_in_a",  "5",          8'h0A, {"E", crlf});
    add_vec("junk_ignore", "+x1a0*0020", 8'h0D, {"200", crlf});
    add_vec("sub_min",     "0-9999",     8'h0D, {"-9999", crlf});
    add_vec("b_overflow",  "3*12345",    8'h00, {"E", crlf});
    foreach (vq[i]) run_vec(vq[i]);

    // error flag timing around ERR
    rx_q.delete();
    type_str("1234");
    @(posedge clk); #1;
    ascii_in = 8'h35; flag = 1'b1;
    @(posedge clk); #1;
    flag = 1'b0; ascii_in = 8'h00;
    chk("err_flag_high", error, 1);
    chk("err_state", state, 6);
    collect(3, 1'b0, got);
    chk_str("err_string", got, {"E", crlf});
    chk("err_flag_low", error, 0);

    // ready stall mid-result, with strobes typed during SEND
    rx_q.delete();
    type_str("12*34");
    key(8'h0D);
    wait_rx(2);
    ready = 1'b0;
    key(8'h37);
    key(8'h2B);
    repeat (42) @(posedge clk);
    #1;
    chk("stall_count", rx_q.size(), 2);
    chk("stall_state", state, 5);
    collect(5, 1'b0, got);
    chk_str("stall_result", got, {"408", crlf});
    run_vec('{"after_stall", "1+1", 8'h0D, {"2", crlf}});

    // asynchronous reset mid-SEND
    rx_q.delete();
    type_str("99*99");
    key(8'h0D);
    wait_rx(2);
    #1 rst = 1'b0;
    #1;
    chk("rst_midsend", {send, ascii_out, state, error}, 0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    rx_q.delete();
    repeat (40) @(posedge clk);
    chk("rst_no_resume", rx_q.size(), 0);
    run_vec('{"after_rst", "2*3", 8'h0D, {"6", crlf}});

    // random expressions with random ready back-pressure
    for (int it = 0; it < 40; it++) begin
      u8     ks[$];
      int    used;
      string exp;
      int    na = $urandom_range(1, 5);
      int    nb = $urandom_range(0, 5);
      u8     ops[3] = '{8'h2B, 8'h2D, 8'h2A};
      for (int j = 0; j < na; j++) begin
        if ($urandom_range(0, 7) == 0) ks.push_back(8'h78);
        ks.push_back(u8'(8'h30 + $urandom_range(0, 9)));
      end
      ks.push_back(ops[$urandom_range(0, 2)]);
      for (int j = 0; j < nb; j++) ks.push_back(u8'(8'h30 + $urandom_range(0, 9)));
      if ($urandom_range(0, 9) == 0) ks.push_back(ops[$urandom_range(0, 2)]);
      ks.push_back($urandom_range(0, 1) ? 8'h0D : 8'h0A);
      model(ks, exp, used);
      rx_q.delete();
      for (int j = 0; j < used; j++) key(ks[j]);
      collect(exp.len(), 1'b1, got);
      chk_str($sformatf("rand_%0d", it), got, exp);
      chk($sformatf("rand_%0d_idle", it), state, 0);
    end

    chk("send_gap", gap_viol, 0);
    chk("out_hold", hold_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/modea_calc_n.md
Name: modea_calc_n

Overview:
- Parametrised multi-digit ASCII calculator, successor to the single-digit Mode A block.
- Accepts keystrokes from the keyboard/UART receive path as one-cycle `flag` strobes. Parses `A op B <Enter>` with operators `+`, `-` and `*`.
- Converts the signed result to decimal and streams it as an ASCII string ending in CR LF to the UART transmit path, using a `ready`/`send` handshake.
- Sits between the RX decoder and the TX serialiser, in the same place as the existing Mode A block.

Parameters:
- DIGITS, 4: maximum decimal digits per operand.
- OP_W, 14: binary operand width. Must satisfy 2^OP_W > 10^DIGITS - 1.
- RES_W (localparam), 2*OP_W+1: signed result width.
- OUT_DIGITS (localparam), 2*DIGITS: maximum decimal digits in the result.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- ascii_in  input  8  received character, valid while flag=1.
- flag  input  1  one-cycle strobe marking a new character.
- ready  input  1  TX path can accept a character.
- send  output  1  one-cycle pulse; ascii_out valid in that cycle.
- ascii_out  output  8  character to transmit.
- state  output  3  current FSM state, for debug/LEDs.
- error  output  1  high from ERR entry until the error string is fully sent.

Behaviour:
- Reset (rst=0, asynchronous):
  - All registers cleared; state=IDLE(0).
  - send=0, ascii_out=8'h00, error=0.
  - Takes effect mid-operation in any state, including mid-transmit. No partial string resumes after release.
- FSM encoding: IDLE=0, OPA=1, OPB=2, CALC=3, CONV=4, SEND=5, ERR=6.
- Character classes:
  - Digit: 8'h30 to 8'h39.
  - Operator: `+` 8'h2B, `-` 8'h2D, `*` 8'h2A.
  - Enter: 8'h0A or 8'h0D.
  - Any other character is ignored in every state.
- Input is sampled only when flag=1 and state is IDLE, OPA or OPB. Flag is ignored in CALC, CONV, SEND and ERR.
- IDLE:
  - Digit: A=d, count=1, go to OPA.
  - Operator or Enter: ignored.
- OPA:
  - Digit: A=A*10+d, count+1. If count is already DIGITS, go to ERR.
  - Operator: latch op, clear B and count, go to OPB.
  - Enter: go to ERR.
- OPB:
  - Digit: B=B*10+d with the same overflow rule, ERR on digit DIGITS+1.
  - Enter with count>=1: go to CALC.
  - Enter with count=0: go to ERR.
  - Operator: go to ERR.
- CALC, exactly 1 cycle:
  - R = A+B, A-B or A*B, computed in RES_W-bit signed arithmetic. A and B are zero-extended.
  - neg = R<0. Magnitude = |R|.
  - Go to CONV.
- CONV:
  - Double-dabble on the magnitude into a BCD buffer of OUT_DIGITS nibbles.
  - Lasts exactly RES_W-1 cycles, then go to SEND.
- SEND, transmits in order:
  - `-` if neg.
  - Decimal digits, most significant first, with leading zeros suppressed. A result of zero sends a single `0`.
  - 8'h0D, then 8'h0A.
  - After the last character, go to IDLE with A, B and count cleared.
- ERR:
  - error=1. Sends `E` (8'h45), 8'h0D, 8'h0A.
  - Then go to IDLE; error drops in the cycle IDLE is entered.
- Handshake:
  - In SEND/ERR, send pulses for 1 cycle when ready=1 and send was 0 in the previous cycle.
  - Maximum rate is one character per 2 cycles.
  - ready=0 stalls indefinitely with no character lost or duplicated.
  - ascii_out holds its value between pulses.
- Simultaneous events: flag arriving in the same cycle as a transition out of OPB is ignored. Characters typed during output are dropped.
- Latency, Enter strobe to first send with ready=1: 1 (OPB to CALC) + 1 (CALC) + RES_W-1 (CONV) + 1 cycles. This is 31 cycles at defaults.

Test Plan:
- `6`, `+`, `3`, Enter (strobes 30 ns apart, ready=1) -> send pulses carry 8'h39, 8'h0D, 8'h0A; state returns to 0.
- `1`,`2`,`-`,`4`,`5`, Enter -> `-`,`3`,`3`,CR,LF (8'h2D, 8'h33, 8'h33, 8'h0D, 8'h0A).
- `9999*9999`, Enter -> "99980001" then CR LF. `0+0`, Enter -> single `0`, CR, LF.
- Five digits for A (DIGITS=4) -> error=1, then `E`, CR, LF, then IDLE. Operator in OPB, or Enter with empty B, -> the same error string.
- ready held 0 for 50 cycles mid-result, then 1 -> remaining characters delivered in order with no duplicates. Flag strobes during SEND produce no effect.
- rst pulled low mid-SEND (asynchronous, between clock edges) -> send=0, ascii_out=0 and state=0 immediately. After release, a fresh `2*3` Enter yields `6`, CR, LF.
